// File: rtl/poly_osc_mixer.sv
// -----------------------------------------------------------------------------
// poly_osc_mixer
//
// Polyphonic oscillator and mixer. Once per audio sample period the eight
// voice slots coming from the MIDI receiver are walked one per clock. Each
// active voice advances its phase accumulator, produces the globally selected
// waveform, is scaled by its velocity and summed. The mixed sample leaves on
// sample_out together with a one-cycle sample_valid strobe.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   on_in         in   [NUM_VOICES-1:0]        voice active flags
//   velocity_in   in   [NUM_VOICES-1:0][2:0]   per-voice velocity
//   note_in       in   [NUM_VOICES-1:0][6:0]   per-voice MIDI note number
//   wave_in       in   [1:0]  0 saw, 1 square, 2 triangle, 3 pulse 25%
//   sample_out    out  signed 16-bit mixed sample, held between strobes
//   sample_valid  out  one-cycle pulse when sample_out updates
//   clip_out      out  high with sample_valid when the mix saturated
//
// Build option
//   MIX_SAT_EN  defined  : output is the accumulator saturated to 16 bits and
//                          clip_out flags saturation.
//               undefined: output is the accumulator >>> 3 (cannot clip) and
//                          clip_out stays 0.
//
// Timing: tick (counter == SAMPLE_DIV-1) in cycle T, voices 0..N-1 in
// T+1..T+N, output register loaded in T+N+1, visible in T+N+2.
// -----------------------------------------------------------------------------
module poly_osc_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_DIV = 2083
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_VOICES-1:0]           on_in,
    input  logic [NUM_VOICES-1:0][2:0]      velocity_in,
    input  logic [NUM_VOICES-1:0][6:0]      note_in,
    input  logic [1:0]                      wave_in,
    output logic signed [15:0]              sample_out,
    output logic                            sample_valid,
    output logic                            clip_out
);

    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
    localparam logic signed [15:0] S16_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nx;
    logic [CNT_W-1:0]          r_cnt;
    logic [VIDX_W-1:0]         r_vidx;
    logic [1:0]                r_wave;
    logic [PHASE_W-1:0]        r_phase [NUM_VOICES];
    logic signed [18:0]        r_acc;

    logic                      w_tick;
    logic                      w_last;
    logic                      w_start;
    logic                      w_voice_en;
    logic                      w_out_en;
    logic                      w_on;
    logic [2:0]                w_vel;
    logic [6:0]                w_note;
    logic [PHASE_W-1:0]        w_phase;
    logic [PHASE_W-1:0]        w_inc;
    logic signed [15:0]        w_wave;
    logic signed [15:0]        w_contrib;

    // Phase increments of the top octave (notes 120..131) for a 24-bit
    // phase at 48 kHz; lower octaves are obtained by right shifts.
    function automatic logic [23:0] f_rom(input logic [3:0] semi);
        case (semi)
            4'd0:    return 24'd2926232;
            4'd1:    return 24'd3100235;
            4'd2:    return 24'd3284585;
            4'd3:    return 24'd3479896;
            4'd4:    return 24'd3686822;
            4'd5:    return 24'd3906052;
            4'd6:    return 24'd4138318;
            4'd7:    return 24'd4384395;
            4'd8:    return 24'd4645104;
            4'd9:    return 24'd4921317;
            4'd10:   return 24'd5213953;
            4'd11:   return 24'd5523991;
            default: return 24'd0;
        endcase
    endfunction

    // The ROM is scaled by 2^(PHASE_W-24) so other phase widths keep pitch.
    function automatic logic [PHASE_W-1:0] f_inc(input logic [6:0] note);
        logic [3:0]          semi;
        logic [3:0]          oct;
        logic [PHASE_W+23:0] scaled;
        semi   = 4'(note % 7'd12);
        oct    = 4'(note / 7'd12);
        scaled = '0;
        scaled[23:0] = f_rom(semi);
        scaled = scaled << PHASE_W;
        scaled = scaled >> 24;
        return PHASE_W'(scaled) >> (4'd10 - oct);
    endfunction

    function automatic logic signed [15:0] f_wave(input logic [1:0] sel,
                                                  input logic [15:0] u);
        logic [15:0] t;
        t = u[15] ? {~u[14:0], 1'b0} : {u[14:0], 1'b0};
        case (sel)
            2'd0:    return signed'(u ^ 16'h8000);
            2'd1:    return u[15] ? S16_MIN : S16_MAX;
            2'd2:    return signed'(t ^ 16'h8000);
            default: return (u[15:14] == 2'b00) ? S16_MAX : S16_MIN;
        endcase
    endfunction

    // (wave * (velocity+1)) >>> 3; the product never exceeds 2^18 in magnitude.
    function automatic logic signed [15:0] f_scale(input logic signed [15:0] w,
                                                   input logic [2:0] vel);
        logic signed [19:0] gain;
        logic signed [19:0] prod;
        gain = signed'({17'd0, vel}) + 20'sd1;
        prod = 20'(w) * gain;
        return 16'(prod >>> 3);
    endfunction

`ifdef MIX_SAT_EN
    function automatic logic signed [15:0] f_sat16(input logic signed [18:0] a);
        if (a > 19'sd32767)  return S16_MAX;
        if (a < -19'sd32768) return S16_MIN;
        return 16'(a);
    endfunction

    function automatic logic f_clipped(input logic signed [18:0] a);
        return (a > 19'sd32767) || (a < -19'sd32768);
    endfunction
`endif

    assign w_tick = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign w_last = (r_vidx == VIDX_W'(NUM_VOICES - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state and datapath enables
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_voice_en = 1'b0;
        w_out_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_start    = 1'b1;
                    w_state_nx = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_voice_en = 1'b1;
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_out_en   = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Voice currently being processed; inputs are read live in its cycle.
    assign w_on      = on_in[r_vidx];
    assign w_vel     = velocity_in[r_vidx];
    assign w_note    = note_in[r_vidx];
    assign w_phase   = r_phase[r_vidx];
    assign w_inc     = f_inc(w_note);
    assign w_wave    = f_wave(r_wave, w_phase[PHASE_W-1 -: 16]);
    assign w_contrib = w_on ? f_scale(w_wave, w_vel) : 16'sd0;

    // Phases and output must start from zero, so the datapath is reset too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_vidx       <= '0;
            r_wave       <= '0;
            r_acc        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            clip_out     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
            end
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CNT_W'(1);
            sample_valid <= w_out_en;
            clip_out     <= 1'b0;

            if (w_start) begin
                r_acc  <= '0;
                r_vidx <= '0;
                r_wave <= wave_in;
            end

            if (w_voice_en) begin
                r_acc           <= r_acc + 19'(w_contrib);
                r_vidx          <= r_vidx + VIDX_W'(1);
                // An idle voice restarts from phase 0 on its next note-on.
                r_phase[r_vidx] <= w_on ? (w_phase + w_inc) : '0;
            end

            if (w_out_en) begin
`ifdef MIX_SAT_EN
                sample_out <= f_sat16(r_acc);
                clip_out   <= f_clipped(r_acc);
`else
                sample_out <= 16'(r_acc >>> 3);
`endif
            end
        end
    end

endmodule

// File: tb/tb_poly_osc_mixer.sv
// -----------------------------------------------------------------------------
// tb_poly_osc_mixer
//
// Scoreboard bench: the stimulus process drives voice settings for each sample
// period and pushes the reference model's expected sample, clip flag and
// arrival cycle into a queue; the monitor pops and compares on every
// sample_valid and checks reset state and output hold on all other cycles.
// The model derives increments from the pitch formula with real arithmetic
// and waveforms from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_poly_osc_mixer;

    localparam int NV = 8;
    localparam int SD = 2083;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NV-1:0]           on_in = '0;
    logic [NV-1:0][2:0]      velocity_in = '0;
    logic [NV-1:0][6:0]      note_in = '0;
    logic [1:0]              wave_in = '0;
    logic signed [15:0]      sample_out;
    logic                    sample_valid;
    logic                    clip_out;

    poly_osc_mixer #(
        .NUM_VOICES (NV),
        .PHASE_W    (24),
        .SAMPLE_DIV (SD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .on_in        (on_in),
        .velocity_in  (velocity_in),
        .note_in      (note_in),
        .wave_in      (wave_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .clip_out     (clip_out)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_q = 1'b1;

    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= rst ? 0 : cyc + 1;
    end

    typedef struct {
        int val;
        bit clip;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   last_out = 0;

    // Stimulus settings: set A applies at the start of a sample, set B
    // replaces it part-way through when a mid-sample change is requested.
    logic [NV-1:0]      a_on,   b_on;
    logic [NV-1:0][2:0] a_vel,  b_vel;
    logic [NV-1:0][6:0] a_note, b_note;
    logic [1:0]         a_wave, b_wave;
    int                 ph[NV];
    int                 ks = 0;

    // ---------------- reference model ----------------
    function automatic int tbl(input int s);
        real f;
        f = 440.0 * $pow(2.0, (s + 51) / 12.0);
        return int'($floor(f * 16777216.0 / 48000.0 + 0.5));
    endfunction

    function automatic int inc_of(input int n);
        return tbl(n % 12) / (1 << (10 - n / 12));
    endfunction

    function automatic int wave_val(input int wv, input int u);
        case (wv)
            0:       return u - 32768;
            1:       return (u >= 32768) ? -32768 : 32767;
            2:       return ((u < 32768) ? 2 * u : 2 * (65535 - u)) - 32768;
            default: return (u < 16384) ? 32767 : -32768;
        endcase
    endfunction

    function automatic int floor8(input int p);
        return (p >= 0) ? p / 8 : -((-p + 7) / 8);
    endfunction

    task automatic push_expected(input int chg_at);
        int   sum;
        int   w;
        int   v;
        int   n;
        bit   on;
        exp_t e;
        sum = 0;
        for (int i = 0; i < NV; i++) begin
            if (i < chg_at) begin
                on = a_on[i]; v = int'(a_vel[i]); n = int'(a_note[i]);
            end else begin
                on = b_on[i]; v = int'(b_vel[i]); n = int'(b_note[i]);
            end
            if (!on) begin
                ph[i] = 0;
            end else begin
                w     = wave_val(int'(a_wave), ph[i] / 256);
                sum  += floor8(w * (v + 1));
                ph[i] = (ph[i] + inc_of(n)) % 16777216;
            end
        end
`ifdef MIX_SAT_EN
        e.val  = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
        e.clip = (sum > 32767) || (sum < -32768);
`else
        e.val  = floor8(sum);
        e.clip = 1'b0;
`endif
        e.cyc = (ks + 1) * SD + 9;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 3 * SD) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            total++;
            bad++;
            $display("FAIL wait_cyc reached=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic drive_a();
        on_in       = a_on;
        velocity_in = a_vel;
        note_in     = a_note;
        wave_in     = a_wave;
    endtask

    task automatic do_sample(input int chg_at);
        wait_cyc(ks * SD + 20);
        drive_a();
        push_expected(chg_at);
        if (chg_at < NV) begin
            wait_cyc((ks + 1) * SD + chg_at);
            on_in       = b_on;
            velocity_in = b_vel;
            note_in     = b_note;
            wave_in     = b_wave;
        end
        ks++;
    endtask

    task automatic do_reset_mid();
        wait_cyc(ks * SD + 20);
        drive_a();
        wait_cyc((ks + 1) * SD + 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NV; i++) ph[i] = 0;
        ks = 0;
    endtask

    task automatic rand_a();
        a_on   = 8'($urandom);
        a_wave = 2'($urandom);
        for (int i = 0; i < NV; i++) begin
            a_vel[i]  = 3'($urandom);
            a_note[i] = 7'($urandom);
        end
    endtask

    task automatic rand_b();
        b_on   = 8'($urandom);
        b_wave = 2'($urandom);
        for (int i = 0; i < NV; i++) begin
            b_vel[i]  = 3'($urandom);
            b_note[i] = 7'($urandom);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            last_out = 0;
            total++;
            if (sample_out !== 16'sd0 || sample_valid !== 1'b0 || clip_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_state out=%0d valid=%b clip=%b required 0/0/0",
                         sample_out, sample_valid, clip_out);
            end
        end else if (sample_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid cyc=%0d out=%0d required no pulse",
                         cyc, sample_out);
            end else begin
                e = exp_q.pop_front();
                if (int'(sample_out) != e.val || clip_out !== e.clip || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL sample out=%0d clip=%b cyc=%0d required out=%0d clip=%b cyc=%0d",
                             sample_out, clip_out, cyc, e.val, e.clip, e.cyc);
                end
                last_out = e.val;
            end
        end else begin
            total++;
            if (int'(sample_out) != last_out || clip_out !== 1'b0 || sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold cyc=%0d out=%0d clip=%b valid=%b required out=%0d clip=0 valid=0",
                         cyc, sample_out, clip_out, sample_valid, last_out);
            end
        end
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        int guard;
        for (int i = 0; i < NV; i++) ph[i] = 0;
        a_on = '0; a_vel = '0; a_note = '0; a_wave = '0;
        b_on = '0; b_vel = '0; b_note = '0; b_wave = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        ks  = 0;

        // all voices off
        do_sample(NV);
        do_sample(NV);

        // saw A4 on voice 0 at full velocity
        a_on = 8'h01; a_vel[0] = 3'd7; a_note[0] = 7'd69; a_wave = 2'd0;
        repeat (3) do_sample(NV);

        // note off then note on again
        a_on = 8'h00;
        do_sample(NV);
        a_on = 8'h01;
        do_sample(NV);

        // full square chord from phase 0
        a_on = 8'h00;
        do_sample(NV);
        a_on = 8'hFF; a_wave = 2'd1;
        for (int i = 0; i < NV; i++) begin
            a_vel[i]  = 3'd7;
            a_note[i] = 7'd60;
        end
        do_sample(NV);

        // minimum velocity on a single voice
        a_on = 8'h00;
        do_sample(NV);
        a_on = 8'h04; a_vel[2] = 3'd0; a_wave = 2'd1;
        do_sample(NV);

        // note range extremes, triangle
        a_on   = 8'hFF;
        a_wave = 2'd2;
        a_note = {7'd127, 7'd120, 7'd119, 7'd60, 7'd59, 7'd12, 7'd11, 7'd0};
        for (int i = 0; i < NV; i++) a_vel[i] = 3'($urandom);
        repeat (3) do_sample(NV);

        // randomized voice settings
        repeat (8) begin
            rand_a();
            do_sample(NV);
        end

        // inputs change after voice 2 has been processed
        rand_a();
        a_on = 8'hFF;
        rand_b();
        do_sample(3);

        // reset during accumulation, then restart from phase 0
        a_on = 8'h01; a_vel[0] = 3'd7; a_note[0] = 7'd69; a_wave = 2'd0;
        do_sample(NV);
        do_reset_mid();
        do_sample(NV);

        guard = 0;
        while (exp_q.size() != 0 && guard < 3 * SD) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/poly_osc_mixer.md
# poly_osc_mixer

Polyphonic oscillator and mixer directly downstream of the MIDI receiver. It consumes the 8-slot voice state (on flags, 3-bit velocities, 7-bit notes, 2-bit wave select) and, once per audio sample period, walks the 8 voices time-multiplexed. For each voice it advances a phase accumulator, generates the selected waveform, scales it by velocity and sums it. It emits one signed 16-bit mixed sample per period with a one-cycle valid strobe for the DAC/PWM stage.

## Interface
- NUM_VOICES, 8, voice slots processed per sample; must match the receiver.
- PHASE_W, 24, phase accumulator width.
- SAMPLE_DIV, 2083, clk cycles per output sample (100 MHz / 2083 ≈ 48 kHz); must be ≥ NUM_VOICES+3.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- on_in  in  [7:0]  voice active flags.
- velocity_in  in  [7:0][2:0]  per-voice velocity.
- note_in  in  [7:0][6:0]  per-voice MIDI note number.
- wave_in  in  [1:0]  global waveform: 0 saw, 1 square, 2 triangle, 3 pulse 25%.
- sample_out  out  16  signed mixed sample, registered.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- clip_out  out  1  set with sample_valid when the mix saturated; otherwise 0.

## Operation
- Reset: sample_out=0, sample_valid=0, clip_out=0, all phases=0, accumulator=0, sample counter=0, FSM=IDLE.
- Sample counter runs 0..SAMPLE_DIV-1 and wraps. The tick is the cycle in which counter==SAMPLE_DIV-1.
- FSM states:
  - IDLE: on tick, clear the accumulator, set voice index=0, go to ACCUM. Latch wave_in for the whole sample.
  - ACCUM: process one voice per cycle. After voice 7, go to DONE.
  - DONE: register the output, then return to IDLE.
- Per-voice processing (inputs sampled in that voice's cycle):
  - Voice off: phase is cleared to 0; contribution is 0.
  - Voice on: generate the waveform from the current phase, then phase += inc (mod 2^PHASE_W).
  - A note change while on does not reset phase.
- Increment: s = note mod 12, o = note / 12 (0..10). inc = TABLE[s] >> (10-o). TABLE[s] = round(2^PHASE_W · 440·2^((s+51)/12) / 48000), a 12-entry constant ROM. Example: TABLE[9] = 4921317, so note 69 gives inc = 153791.
- Waveform, using u = phase[PHASE_W-1 -: 16] (unsigned):
  - saw = u ^ 0x8000, taken as signed.
  - square = u[15] ? -32768 : +32767.
  - triangle: t = u[15] ? (~u[14:0])<<1 : u[14:0]<<1 (16-bit), then t ^ 0x8000.
  - pulse = (u[15:14]==0) ? +32767 : -32768.
- Scaling: contribution = (wave × (velocity+1)) >>> 3, a 16-bit signed result.
- Accumulator: 19-bit signed.

## Timing
- Tick in cycle T. Voices 0..7 are processed in cycles T+1..T+8. DONE is in T+9.
- sample_out, clip_out and sample_valid are visible in cycle T+10; sample_valid is exactly one cycle wide.
- sample_valid pulses are spaced exactly SAMPLE_DIV cycles apart.
- The first tick after reset is in cycle SAMPLE_DIV-1, counting the first post-reset cycle as 0.
- Input changes in the middle of a sample affect only voices not yet processed in that sample.
- rst asserted in any state (including mid-ACCUM) returns everything to reset values next cycle. The partial sample is discarded and no valid pulse is emitted.
- sample_out holds its value between valid pulses.

## Configuration
- MIX_SAT_EN defined: sample_out = accumulator saturated to [-32768, 32767]; clip_out=1 when saturation occurred.
- MIX_SAT_EN undefined: sample_out = accumulator >>> 3, which never clips; clip_out is tied to 0.

## Test plan
- Reset/idle: release rst with all voices off → sample_valid first at cycle SAMPLE_DIV+9, then every 2083 cycles; sample_out=0, clip_out=0.
- Saw A4: voice 0 on, note 69, vel 7, wave 0 → first sample contribution -32768 (sat: -32768; no-sat: -4096). Second sample u=600, contribution -32168. Phase advances by 153791 per sample.
- Full square chord: all 8 voices on, note 60, vel 7, wave 1, from phase 0 → sum 262136. Sat: sample_out=32767, clip_out=1. No-sat: sample_out=32767, clip_out=0.
- Velocity scaling: voice 2 only, square, vel 0, sat build → sample_out=4095.
- Note off/on: drop on_in[0] → next sample contribution 0 and phase 0. Reassert → output restarts from phase 0 (saw -32768 at vel 7).
- Reset mid-ACCUM: pulse rst during cycle T+4 → no valid pulse for that sample, phases 0, next valid at SAMPLE_DIV+9 after release.
